mcu_cmd_sequencer: RTL and testbench
====================================

MCU_CMD_SEQUENCER -- requirements
Module: mcu_cmd_sequencer

Interface
REQ-001 SHALL have parameter PHASE_INC_WIDTH, default 27, DDS phase-increment width; legal range 1..28.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, frequency-change event FIFO depth; power of two, 2..64.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port aclk, input, 1, system clock; all logic on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port fq_change, input, 8, signed frequency-change sample.
REQ-007 SHALL have port fq_change_valid, input, 1, fq_change qualifier; one event per rising edge.
REQ-008 SHALL have port from_mcu, input, 32, MCU GPIO word: [31:28] command, [27:0] data.
REQ-009 SHALL have port to_mcu, output, 32, response: [31] done, [30] error, [29] empty, [28] overflow, [27:0] payload.
REQ-010 SHALL have port fq_irq, output, 1, MCU interrupt, high while the FIFO is non-empty.
REQ-011 SHALL have port phase_inc, output, PHASE_INC_WIDTH, DDS phase increment.
REQ-012 SHALL have port phase_inc_valid, output, 1, phase_inc qualifier.
REQ-013 SHALL have port phase_inc_ready, input, 1, DDS accepts phase_inc when high with valid.

Function
REQ-014 SHALL register from_mcu once (from_mcu_q); all decoding uses from_mcu_q.
REQ-015 SHALL detect fq_change_valid rising edges (0 in previous cycle, 1 now) and push fq_change into the FIFO that cycle.
REQ-016 SHALL drop a push when the FIFO is full and no pop occurs that cycle, and set a sticky overflow flag.
REQ-017 SHALL accept a push and a pop in the same cycle, including when full or empty-then-push; count unchanged; no overflow.
REQ-018 SHALL implement states IDLE, EXEC, WAIT_DDS, RESPOND.
REQ-019 IDLE: command 0x0 -> stay; any other command -> latch command and data, go EXEC next edge.
REQ-020 EXEC, command 0x1 GET_FQ_INC: pop if non-empty; payload = sign-extended popped value, empty=0; if empty: no pop, payload 0, empty=1; go RESPOND.
REQ-021 EXEC, command 0x2 SET_PHASE_INC: load phase_inc = data[PHASE_INC_WIDTH-1:0], set phase_inc_valid, go WAIT_DDS.
REQ-022 WAIT_DDS: hold phase_inc and phase_inc_valid stable; on the edge sampling phase_inc_ready=1, clear valid and go RESPOND; no timeout.
REQ-023 EXEC, command 0x3 GET_STATUS: payload[6:0] = FIFO count; no pop; go RESPOND.
REQ-024 EXEC, command 0x4 CLEAR: flush FIFO, clear overflow (an overflow in the same cycle loses to clear); go RESPOND.
REQ-025 EXEC, any other command: error=1, payload 0, no side effect; go RESPOND.
REQ-026 On entry to RESPOND, to_mcu SHALL update with done=1; bits [29:28] reflect state after the action.
REQ-027 RESPOND: hold to_mcu until from_mcu_q command = 0x0, then clear done and error the same edge, return IDLE; a changed non-zero command is ignored.
REQ-028 Latency: command presented at edge k -> to_mcu done at edge k+3 (non-DDS commands); SET_PHASE_INC done 1 edge after ready sampled.
REQ-029 to_mcu[28] SHALL track live overflow in IDLE; to_mcu[29] live empty in IDLE.
REQ-030 fq_irq SHALL be registered, reflecting non-empty one cycle after FIFO state.
REQ-031 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).

Reset
REQ-032 reset_n low SHALL asynchronously force state IDLE, FIFO empty, overflow 0, to_mcu 0, fq_irq 0, phase_inc 0, phase_inc_valid 0, edge detector previous value 0.
REQ-033 Reset mid-command, including in WAIT_DDS, SHALL abort without completion; after release, a non-zero command still present on from_mcu SHALL be executed anew.
REQ-034 Release SHALL be synchronous to aclk externally; block needs no internal synchronizer.

Verification
REQ-035 Push fq_change 0x05 then 0xFB; GET_FQ_INC twice -> payloads 0x0000005, 0xFFFFFFB; fq_irq falls after second pop; a third GET -> empty=1, payload 0.
REQ-036 Nine pushes with depth 8 -> count 8, overflow=1 via GET_STATUS (payload 8); CLEAR -> count 0, overflow 0, fq_irq 0.
REQ-037 SET_PHASE_INC data 0x1234567, phase_inc_ready low 5 cycles -> phase_inc 0x1234567 with valid held 5 cycles; done 1 edge after ready.
REQ-038 FIFO full, push and GET_FQ_INC pop same cycle -> count stays 8, overflow stays 0.
REQ-039 Command 0x7 -> done=1, error=1; command held -> no re-execution until 0x0 then 0x7 again.
REQ-040 reset_n low during WAIT_DDS -> phase_inc_valid 0 immediately, to_mcu 0; after release, still-present 0x2 reissues valid.

Source files
------------

// File: rtl/mcu_cmd_sequencer.sv
// MCU command sequencer: buffers signed frequency-change events in a small FIFO
// and executes MCU GPIO commands, including a ready/valid DDS phase-increment load.
module mcu_cmd_sequencer #(
  parameter int PHASE_INC_WIDTH = 27,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic                       aclk,
  input  logic                       reset_n,
  input  logic signed [7:0]          fq_change,
  input  logic                       fq_change_valid,
  input  logic [31:0]                from_mcu,
  output logic [31:0]                to_mcu,
  output logic                       fq_irq,
  output logic [PHASE_INC_WIDTH-1:0] phase_inc,
  output logic                       phase_inc_valid,
  input  logic                       phase_inc_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  localparam logic [3:0] CMD_NOP           = 4'h0;
  localparam logic [3:0] CMD_GET_FQ_INC    = 4'h1;
  localparam logic [3:0] CMD_SET_PHASE_INC = 4'h2;
  localparam logic [3:0] CMD_GET_STATUS    = 4'h3;
  localparam logic [3:0] CMD_CLEAR         = 4'h4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WAIT_DDS,
    S_RESPOND
  } state_t;

  state_t                     r_state;
  logic [31:0]                r_from_mcu_q;
  logic [3:0]                 r_cmd;
  logic [27:0]                r_data;
  logic [31:0]                r_to_mcu;
  logic [PHASE_INC_WIDTH-1:0] r_phase_inc;
  logic                       r_phase_inc_valid;

  logic                       r_fq_valid_prev;
  logic [7:0]                 r_mem [FIFO_DEPTH];
  logic [AW-1:0]              r_wr_ptr;
  logic [AW-1:0]              r_rd_ptr;
  logic [CW-1:0]              r_count;
  logic                       r_overflow;
  logic                       r_fq_irq;

  logic                       w_exec;
  logic                       w_empty;
  logic                       w_full;
  logic                       w_push_req;
  logic                       w_pop;
  logic                       w_clear;
  logic                       w_push;
  logic                       w_drop;
  logic [CW-1:0]              w_count_next;
  logic                       w_overflow_next;
  logic [1:0]                 w_flags_next;
  logic [7:0]                 w_rd_data;
  logic                       w_unused_data;

  // Data bits above the phase-increment width carry no meaning for any command.
  assign w_unused_data = ^r_data;

  assign w_exec     = (r_state == S_EXEC);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(FIFO_DEPTH));
  assign w_push_req = fq_change_valid & ~r_fq_valid_prev;
  assign w_pop      = w_exec && (r_cmd == CMD_GET_FQ_INC) && !w_empty;
  assign w_clear    = w_exec && (r_cmd == CMD_CLEAR);
  // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
  assign w_push     = w_push_req && !w_clear && (!w_full || w_pop);
  assign w_drop     = w_push_req && !w_clear && w_full && !w_pop;
  assign w_rd_data  = r_mem[r_rd_ptr];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_count_next    = r_count;
    w_overflow_next = r_overflow;
    if (w_clear) begin
      w_count_next    = '0;
      w_overflow_next = 1'b0;
    end else begin
      if (w_push && !w_pop) w_count_next = r_count + CW'(1);
      if (!w_push && w_pop) w_count_next = r_count - CW'(1);
      if (w_drop)           w_overflow_next = 1'b1;
    end
  end

  assign w_flags_next = {(w_count_next == '0), w_overflow_next};

  // NOTE: the event storage has no reset; pointers and count alone qualify its contents.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= fq_change;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      r_fq_valid_prev <= 1'b0;
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_overflow      <= 1'b0;
      r_fq_irq        <= 1'b0;
    end else begin
      r_fq_valid_prev <= fq_change_valid;
      r_count         <= w_count_next;
      r_overflow      <= w_overflow_next;
      r_fq_irq        <= !w_empty;
      if (w_clear) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state           <= S_IDLE;
      r_from_mcu_q      <= '0;
      r_cmd             <= CMD_NOP;
      r_data            <= '0;
      r_to_mcu          <= '0;
      r_phase_inc       <= '0;
      r_phase_inc_valid <= 1'b0;
    end else begin
      r_from_mcu_q <= from_mcu;
      case (r_state)
        S_IDLE: begin
          r_to_mcu[29:28] <= w_flags_next;
          if (r_from_mcu_q[31:28] != CMD_NOP) begin
            r_cmd   <= r_from_mcu_q[31:28];
            r_data  <= r_from_mcu_q[27:0];
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= S_RESPOND;
          case (r_cmd)
            CMD_GET_FQ_INC: begin
              // The empty bit reports whether this GET found nothing to pop.
              r_to_mcu <= {1'b1, 1'b0, w_empty, w_overflow_next,
                           w_pop ? {{20{w_rd_data[7]}}, w_rd_data} : 28'd0};
            end
            CMD_SET_PHASE_INC: begin
              r_phase_inc       <= r_data[PHASE_INC_WIDTH-1:0];
              r_phase_inc_valid <= 1'b1;
              r_state           <= S_WAIT_DDS;
            end
            CMD_GET_STATUS: r_to_mcu <= {2'b10, w_flags_next, 28'(r_count)};
            CMD_CLEAR:      r_to_mcu <= {2'b10, w_flags_next, 28'd0};
            default:        r_to_mcu <= {2'b11, w_flags_next, 28'd0};
          endcase
        end
        S_WAIT_DDS: begin
          if (phase_inc_ready) begin
            r_phase_inc_valid <= 1'b0;
            r_to_mcu          <= {2'b10, w_flags_next, 28'd0};
            r_state           <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          if (r_from_mcu_q[31:28] == CMD_NOP) begin
            r_to_mcu[31:30] <= 2'b00;
            r_to_mcu[29:28] <= w_flags_next;
            r_state         <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign to_mcu          = r_to_mcu;
  assign fq_irq          = r_fq_irq;
  assign phase_inc       = r_phase_inc;
  assign phase_inc_valid = r_phase_inc_valid;

endmodule

// File: tb/tb_mcu_cmd_sequencer.sv
// Bench for mcu_cmd_sequencer: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mcu_cmd_sequencer;

  localparam int PIW   = 27;
  localparam int DEPTH = 8;

  logic              aclk = 1'b0;
  logic              reset_n;
  logic signed [7:0] fq_change;
  logic              fq_change_valid;
  logic [31:0]       from_mcu;
  logic [31:0]       to_mcu;
  logic              fq_irq;
  logic [PIW-1:0]    phase_inc;
  logic              phase_inc_valid;
  logic              phase_inc_ready;

  int n_checks = 0;
  int n_errors = 0;

  mcu_cmd_sequencer #(.PHASE_INC_WIDTH(PIW), .FIFO_DEPTH(DEPTH)) dut (
    .aclk            (aclk),
    .reset_n         (reset_n),
    .fq_change       (fq_change),
    .fq_change_valid (fq_change_valid),
    .from_mcu        (from_mcu),
    .to_mcu          (to_mcu),
    .fq_irq          (fq_irq),
    .phase_inc       (phase_inc),
    .phase_inc_valid (phase_inc_valid),
    .phase_inc_ready (phase_inc_ready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, command protocol as issue/response timing.
  int          cyc = 0;
  logic [7:0]  m_q[$];
  bit          m_ovf = 0, m_prev = 0;
  logic [31:0] m_from_q = '0;
  bit          m_busy = 0, m_wait_dds = 0, m_held = 0;
  int          m_exec_cyc = 0;
  logic [31:0] m_cmdword = '0;
  bit          m_push, m_pop, m_act;
  int          m_old_count;
  logic [7:0]  m_popped;
  logic [1:0]  m_flags;
  logic [31:0] e_to_mcu = '0;
  bit          e_irq = 0, e_pvalid = 0;
  logic [PIW-1:0] e_pinc = '0;

  always @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_ovf = 0; m_prev = 0; m_from_q = '0;
      m_busy = 0; m_wait_dds = 0; m_held = 0;
      e_to_mcu = '0; e_irq = 0; e_pinc = '0; e_pvalid = 0;
    end else begin
      cyc++;
      m_push      = fq_change_valid && !m_prev;
      m_act       = m_busy && (cyc == m_exec_cyc);
      m_old_count = m_q.size();
      m_pop       = m_act && (m_cmdword[31:28] == 4'h1) && (m_old_count != 0);
      m_popped    = m_pop ? m_q[0] : 8'h00;
      if (m_act && m_cmdword[31:28] == 4'h4) begin
        m_q.delete();
        m_ovf = 0;
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_push) begin
          if (m_q.size() < DEPTH) m_q.push_back(fq_change);
          else m_ovf = 1;
        end
      end
      m_flags = {m_q.size() == 0, m_ovf};
      if (m_held) begin
        if (m_from_q[31:28] == 4'h0) begin
          m_held = 0;
          e_to_mcu[31:28] = {2'b00, m_flags};
        end
      end else if (m_wait_dds) begin
        if (phase_inc_ready) begin
          m_wait_dds = 0; e_pvalid = 0; m_held = 1;
          e_to_mcu = {2'b10, m_flags, 28'd0};
        end
      end else if (m_act) begin
        m_busy = 0;
        m_held = 1;
        case (m_cmdword[31:28])
          4'h1: e_to_mcu = {2'b10, !m_pop, m_ovf,
                            m_pop ? {{20{m_popped[7]}}, m_popped} : 28'd0};
          4'h2: begin
            m_held = 0; m_wait_dds = 1;
            e_pinc = m_cmdword[PIW-1:0]; e_pvalid = 1;
          end
          4'h3: e_to_mcu = {2'b10, m_flags, 28'(m_old_count)};
          4'h4: e_to_mcu = {2'b10, m_flags, 28'd0};
          default: e_to_mcu = {2'b11, m_flags, 28'd0};
        endcase
      end else if (!m_busy) begin
        e_to_mcu[29:28] = m_flags;
        if (m_from_q[31:28] != 4'h0) begin
          m_busy = 1; m_exec_cyc = cyc + 1; m_cmdword = m_from_q;
        end
      end
      e_irq    = (m_old_count != 0);
      m_from_q = from_mcu;
      m_prev   = fq_change_valid;
    end
  end

  always @(negedge aclk) begin
    check("cmp_to_mcu", to_mcu, e_to_mcu);
    check("cmp_fq_irq", {31'd0, fq_irq}, {31'd0, e_irq});
    check("cmp_pvalid", {31'd0, phase_inc_valid}, {31'd0, e_pvalid});
    check("cmp_phase_inc", 32'(phase_inc), 32'(e_pinc));
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_evt(input logic [7:0] v);
    fq_change = v; fq_change_valid = 1'b1;
    tick();
    fq_change_valid = 1'b0;
    tick();
  endtask

  task automatic run_cmd(input string name, input logic [3:0] cmd, input logic [27:0] data,
                         output logic [31:0] resp);
    int waited = 0;
    from_mcu = {cmd, data};
    do begin tick(); waited++; end while (to_mcu[31] !== 1'b1 && waited < 20);
    check({name, "_latency"}, waited, 3);
    resp = to_mcu;
  endtask

  task automatic release_cmd(input string name);
    int waited = 0;
    from_mcu = '0;
    do begin tick(); waited++; end while (to_mcu[31] !== 1'b0 && waited < 20);
    check({name, "_release"}, waited, 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    int waited;
    reset_n = 1'b0; fq_change = '0; fq_change_valid = 1'b0;
    from_mcu = '0; phase_inc_ready = 1'b1;
    repeat (3) tick();
    check("rst_to_mcu", to_mcu, 32'h0);
    check("rst_irq", {31'd0, fq_irq}, 32'd0);
    check("rst_pvalid", {31'd0, phase_inc_valid}, 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();
    check("idle_empty_flag", {30'd0, to_mcu[29:28]}, 32'd2);

    // Two events, pop both, then a GET on an empty FIFO.
    push_evt(8'h05);
    push_evt(8'hFB);
    check("irq_after_push", {31'd0, fq_irq}, 32'd1);
    run_cmd("get1", 4'h1, 28'h0, r);
    check("get1_payload", {4'h0, r[27:0]}, 32'h0000005);
    check("get1_flags", {28'd0, r[31:28]}, 32'h8);
    release_cmd("get1");
    run_cmd("get2", 4'h1, 28'h0, r);
    check("get2_payload", {4'h0, r[27:0]}, 32'h0FFFFFFB);
    release_cmd("get2");
    check("irq_after_pops", {31'd0, fq_irq}, 32'd0);
    run_cmd("get3", 4'h1, 28'h0, r);
    check("get3_resp", r, 32'hA000_0000);
    release_cmd("get3");

    // Overflow: nine events into a depth-8 FIFO, then CLEAR.
    for (int i = 0; i < 9; i++) push_evt(8'(i + 1));
    run_cmd("stat_ovf", 4'h3, 28'h0, r);
    check("stat_ovf_resp", r, 32'h9000_0008);
    release_cmd("stat_ovf");
    run_cmd("clear", 4'h4, 28'h0, r);
    check("clear_resp", r, 32'hA000_0000);
    release_cmd("clear");
    check("clear_irq", {31'd0, fq_irq}, 32'd0);
    check("clear_idle_flags", {30'd0, to_mcu[29:28]}, 32'd2);

    // Full FIFO: push and pop land on the same edge.
    for (int i = 0; i < 8; i++) push_evt(8'(8'h10 + i));
    from_mcu = {4'h1, 28'h0};
    tick(); tick();
    fq_change = 8'h33; fq_change_valid = 1'b1;
    tick();
    fq_change_valid = 1'b0;
    check("fullpp_resp", to_mcu, 32'h8000_0010);
    release_cmd("fullpp");
    run_cmd("fullpp_stat", 4'h3, 28'h0, r);
    check("fullpp_stat_resp", r, 32'h8000_0008);
    release_cmd("fullpp_stat");

    // DDS load with ready held low for five cycles.
    phase_inc_ready = 1'b0;
    from_mcu = {4'h2, 28'h1234567};
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      check("dds_valid_held", {31'd0, phase_inc_valid}, 32'd1);
      check("dds_value_held", 32'(phase_inc), 32'h01234567);
      check("dds_not_done", {31'd0, to_mcu[31]}, 32'd0);
      if (i < 4) tick();
    end
    phase_inc_ready = 1'b1;
    tick();
    check("dds_done", to_mcu, 32'h8000_0000);
    check("dds_valid_clr", {31'd0, phase_inc_valid}, 32'd0);
    release_cmd("dds");

    // Illegal command, held and changed while responding, then reissued.
    run_cmd("bad1", 4'h7, 28'h0, r);
    check("bad1_resp", {r[31:30], 2'b00, r[27:0]}, 32'hC000_0000);
    repeat (4) tick();
    from_mcu = {4'h3, 28'h0};
    repeat (5) tick();
    check("bad_hold", {to_mcu[31:30], 2'b00, to_mcu[27:0]}, 32'hC000_0000);
    release_cmd("bad1");
    run_cmd("bad2", 4'h7, 28'h0, r);
    check("bad2_err", {30'd0, r[31:30]}, 32'd3);
    release_cmd("bad2");

    // Reset during WAIT_DDS aborts; the still-present command runs again.
    phase_inc_ready = 1'b0;
    from_mcu = {4'h2, 28'h0ABCDEF};
    repeat (3) tick();
    check("rdds_valid", {31'd0, phase_inc_valid}, 32'd1);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("rdds_async_valid", {31'd0, phase_inc_valid}, 32'd0);
    check("rdds_async_to_mcu", to_mcu, 32'h0);
    check("rdds_async_pinc", 32'(phase_inc), 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    waited = 0;
    do begin tick(); waited++; end while (phase_inc_valid !== 1'b1 && waited < 20);
    check("rdds_reissue_lat", waited, 3);
    check("rdds_reissue_pinc", 32'(phase_inc), 32'h00ABCDEF);
    phase_inc_ready = 1'b1;
    tick();
    check("rdds_done", {31'd0, to_mcu[31]}, 32'd1);
    release_cmd("rdds");
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
